// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register writer: frame layout, peripheral
// register map, controller FSM states and the frame packing helper.
package spi_reg_pkg;

    localparam int FRAME_W = 16;
    localparam int RW_BIT  = 15;

    // Register map of the SPI register peripheral
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;  // en_out[7:0]
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;  // en_out[15:8]
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;  // en_pwm[7:0]
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;  // en_pwm[15:8]
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;  // pwm_duty

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // Write frame: write flag, 7-bit address, 8-bit data, sent MSB first
    function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] addr,
                                                       input logic [7:0] data);
        return {1'b1, addr, data};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider. While enabled, sclk toggles every CLK_DIV cycles
// starting from low; rise_tick/fall_tick flag the cycle whose closing edge
// makes sclk go high/low. clear parks the divider with sclk low.
module spi_sclk_gen
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_r;
    logic             sclk_r;
    logic             at_end_s;

    // Decode the end of a half period into edge strobes for the controller
    always_comb begin
        at_end_s  = 1'b0;
        rise_tick = 1'b0;
        fall_tick = 1'b0;
        if (enable && (div_cnt_r == LAST)) begin
            at_end_s  = 1'b1;
            rise_tick = ~sclk_r;
            fall_tick = sclk_r;
        end else begin
            at_end_s  = 1'b0;
        end
    end

    // Half-period counter and registered sclk level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            sclk_r    <= 1'b0;
        end else if (clear) begin
            div_cnt_r <= '0;
            sclk_r    <= 1'b0;
        end else if (at_end_s) begin
            div_cnt_r <= '0;
            sclk_r    <= ~sclk_r;
        end else if (enable) begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    assign sclk = sclk_r;

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 controller issuing one 16-bit write frame per accepted
// address/data request. FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
// The single IDLE cycle before the next accept counts toward the ncs-high
// gap, so GAP itself lasts CS_IDLE-1 cycles (at least one, to carry done).
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       ncs,
    output logic       sclk,
    output logic       copi
);

    localparam int GAP_LEN = (CS_IDLE > 1) ? (CS_IDLE - 1) : 1;

    spi_state_e         state_r;
    logic [FRAME_W-1:0] shift_r;
    logic [FRAME_W-1:0] frame_s;
    logic [15:0]        cyc_cnt_r;
    logic [3:0]         bit_cnt_r;
    logic               last_bit_r;
    logic               ncs_r;
    logic               copi_r;
    logic               req_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               gen_enable_s;
    logic               gen_clear_s;
    logic               rise_tick_s;
    logic               fall_tick_s;

    // Frame packing and divider control derived from the current state
    always_comb begin
        frame_s      = build_frame(req_addr, req_data);
        gen_enable_s = 1'b0;
        gen_clear_s  = 1'b1;
        if (state_r == ST_SHIFT) begin
            gen_enable_s = 1'b1;
            gen_clear_s  = 1'b0;
        end else begin
            gen_enable_s = 1'b0;
            gen_clear_s  = 1'b1;
        end
    end

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .enable    (gen_enable_s),
        .clear     (gen_clear_s),
        .rise_tick (rise_tick_s),
        .fall_tick (fall_tick_s),
        .sclk      (sclk)
    );

    // Frame sequencer: handshake, shift register, phase timing, registered pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            cyc_cnt_r   <= 16'd0;
            bit_cnt_r   <= 4'd0;
            last_bit_r  <= 1'b0;
            ncs_r       <= 1'b1;
            copi_r      <= 1'b0;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cyc_cnt_r  <= 16'd0;
                    bit_cnt_r  <= 4'd0;
                    last_bit_r <= 1'b0;
                    if (req_valid && req_ready_r) begin
                        shift_r     <= frame_s;
                        copi_r      <= frame_s[RW_BIT];
                        ncs_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_SETUP;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cyc_cnt_r == 16'(CS_SETUP - 1)) begin
                        cyc_cnt_r <= 16'd0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    // The decision to stop is taken at the 16th rising edge,
                    // the state ends on the falling edge that follows it
                    if (rise_tick_s) begin
                        last_bit_r <= (bit_cnt_r == 4'd15);
                    end
                    if (fall_tick_s) begin
                        if (last_bit_r) begin
                            bit_cnt_r  <= 4'd0;
                            last_bit_r <= 1'b0;
                            state_r    <= ST_HOLD;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
                            copi_r    <= shift_r[FRAME_W-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (cyc_cnt_r == 16'(CS_HOLD - 1)) begin
                        cyc_cnt_r <= 16'd0;
                        ncs_r     <= 1'b1;
                        copi_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= ST_GAP;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cyc_cnt_r == 16'(GAP_LEN - 1)) begin
                        cyc_cnt_r   <= 16'd0;
                        busy_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cyc_cnt_r   <= 16'd0;
                    bit_cnt_r   <= 4'd0;
                    last_bit_r  <= 1'b0;
                    ncs_r       <= 1'b1;
                    copi_r      <= 1'b0;
                    req_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ncs       = ncs_r;
    assign copi      = copi_r;

endmodule
